// File: rtl/sha1_pkg.sv
// Shared constants and types for the SHA-1 message controller and its pad unit.
package sha1_pkg;

  localparam int DATA_W     = 32;
  localparam int DIGEST_W   = 160;
  localparam int MAXWORDS   = 2**27;
  localparam int BLK_WORDS  = 16;
  localparam int LEN_HI_IDX = 14;
  localparam int LEN_LO_IDX = 15;

  localparam logic [DATA_W-1:0] H0 = 32'h6745_2301;
  localparam logic [DATA_W-1:0] H1 = 32'hEFCD_AB89;
  localparam logic [DATA_W-1:0] H2 = 32'h98BA_DCFE;
  localparam logic [DATA_W-1:0] H3 = 32'h1032_5476;
  localparam logic [DATA_W-1:0] H4 = 32'hC3D2_E1F0;

  localparam logic [DATA_W-1:0] K0 = 32'h5A82_7999;
  localparam logic [DATA_W-1:0] K1 = 32'h6ED9_EBA1;
  localparam logic [DATA_W-1:0] K2 = 32'h8F1B_BCDC;
  localparam logic [DATA_W-1:0] K3 = 32'hCA62_C1D6;

  localparam logic [DATA_W-1:0] PAD_MARKER = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    PAD,
    WAITC,
    BURST,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/sha1_pad_unit.sv
// Combinational padding helpers: final-word masking with 0x80 insertion and
// selection of the word written on each PAD cycle.
module sha1_pad_unit
  import sha1_pkg::*;
(
  input  logic [DATA_W-1:0] iDat,
  input  logic [1:0]        iBytes,
  input  logic [63:0]       bitCnt,
  input  logic [3:0]        idx,
  input  logic              markerPending,
  input  logic              lenFits,
  output logic [DATA_W-1:0] lastWord,
  output logic [DATA_W-1:0] padWord
);

  // Bytes below the valid ones are don't-care from the host, so force them.
  always_comb begin
    lastWord = iDat;
    unique case (iBytes)
      2'd1:    lastWord = {iDat[31:24], 8'h80, 16'h0000};
      2'd2:    lastWord = {iDat[31:16], 8'h80, 8'h00};
      2'd3:    lastWord = {iDat[31:8], 8'h80};
      default: lastWord = iDat;
    endcase
  end

  always_comb begin
    padWord = '0;
    if (markerPending) begin
      padWord = PAD_MARKER;
    end else if (lenFits && idx == 4'(LEN_HI_IDX)) begin
      padWord = bitCnt[63:32];
    end else if (lenFits && idx == 4'(LEN_LO_IDX)) begin
      padWord = bitCnt[31:0];
    end
  end

endmodule

// File: rtl/sha1_msg_ctrl.sv
// Message-side controller for the SHA-1 core: buffers and pads 512-bit blocks,
// bursts them into the core and captures the final digest.
module sha1_msg_ctrl
  import sha1_pkg::*;
(
  input  logic                iClk,
  input  logic                reset_n,
  input  logic [DATA_W-1:0]   iDat,
  input  logic                iValid,
  input  logic                iLast,
  input  logic [1:0]          iBytes,
  output logic                oAccept,
  output logic [DATA_W-1:0]   oCoreDat,
  output logic                oCoreValid,
  output logic                oCoreInitial,
  output logic                oCoreRst,
  input  logic                iCoreReady,
  input  logic [DIGEST_W-1:0] iCoreDat,
  output logic [DIGEST_W-1:0] oDigest,
  output logic                oDigestValid
);

  state_t              state;
  state_t              nextState;
  logic [DATA_W-1:0]   msgBuf [BLK_WORDS];
  logic [3:0]          idx;
  logic [3:0]          burstIdx;
  logic [63:0]         bitCnt;
  logic                acceptEn;
  logic                markerPending;
  logic                lenFits;
  logic                padPending;
  logic                lastBlk;
  logic                firstBlk;
  logic                sawLow;
  logic                coreRst;
  logic [DIGEST_W-1:0] digest;
  logic                digestValid;
  logic                take;
  logic                coreBack;
  logic [63:0]         addBits;
  logic [DATA_W-1:0]   lastWord;
  logic [DATA_W-1:0]   padWord;

  sha1_pad_unit padUnit (
    .iDat          (iDat),
    .iBytes        (iBytes),
    .bitCnt        (bitCnt),
    .idx           (idx),
    .markerPending (markerPending),
    .lenFits       (lenFits),
    .lastWord      (lastWord),
    .padWord       (padWord)
  );

  assign take     = iValid && oAccept;
  assign coreBack = sawLow && iCoreReady;
  assign addBits  = (iLast && iBytes != 2'd0) ? 64'({iBytes, 3'b000}) : 64'd32;

  always_ff @(posedge iClk) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE, FILL: begin
        if (take) begin
          if (idx == 4'd15) nextState = WAITC;
          else if (iLast)   nextState = PAD;
          else              nextState = FILL;
        end
      end
      PAD:     if (idx == 4'd15) nextState = WAITC;
      WAITC:   if (iCoreReady) nextState = BURST;
      BURST:   if (burstIdx == 4'd15) nextState = RUN;
      RUN: begin
        if (coreBack) begin
          if (lastBlk)         nextState = DONE;
          else if (padPending) nextState = PAD;
          else                 nextState = FILL;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    oAccept      = acceptEn && (state == IDLE || state == FILL);
    oCoreValid   = (state == BURST);
    oCoreDat     = (state == BURST) ? msgBuf[burstIdx] : '0;
    oCoreInitial = (state == BURST) && firstBlk && (burstIdx == 4'd0);
  end

  // Control registers: the only state cleared by reset_n besides the digest.
  always_ff @(posedge iClk) begin
    if (!reset_n) begin
      idx           <= '0;
      burstIdx      <= '0;
      bitCnt        <= '0;
      acceptEn      <= 1'b0;
      markerPending <= 1'b0;
      lenFits       <= 1'b0;
      padPending    <= 1'b0;
      lastBlk       <= 1'b0;
      firstBlk      <= 1'b0;
      sawLow        <= 1'b0;
      digest        <= '0;
      digestValid   <= 1'b0;
    end else begin
      acceptEn    <= 1'b1;
      digestValid <= 1'b0;
      unique case (state)
        IDLE, FILL: begin
          if (take) begin
            idx    <= idx + 4'd1;
            bitCnt <= bitCnt + addBits;
            if (state == IDLE) firstBlk <= 1'b1;
            if (iLast) begin
              padPending    <= 1'b1;
              markerPending <= (iBytes == 2'd0);
              if (iBytes != 2'd0) lenFits <= (idx <= 4'd13);
            end
          end
        end
        PAD: begin
          idx           <= idx + 4'd1;
          markerPending <= 1'b0;
          if (markerPending) lenFits <= (idx <= 4'd13);
          if (idx == 4'd15 && lenFits && !markerPending) begin
            lastBlk    <= 1'b1;
            padPending <= 1'b0;
          end
        end
        WAITC: begin
          burstIdx <= '0;
          sawLow   <= 1'b0;
        end
        BURST: begin
          burstIdx <= burstIdx + 4'd1;
          if (!iCoreReady)        sawLow   <= 1'b1;
          if (burstIdx == 4'd15)  firstBlk <= 1'b0;
        end
        RUN: begin
          if (!iCoreReady) sawLow <= 1'b1;
          if (coreBack) begin
            idx <= '0;
            if (lastBlk) begin
              digest      <= iCoreDat;
              digestValid <= 1'b1;
            end else if (padPending) begin
              lenFits <= 1'b1;
            end
          end
        end
        DONE: begin
          bitCnt     <= '0;
          lastBlk    <= 1'b0;
          padPending <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Block buffer: data only, never reset.
  always_ff @(posedge iClk) begin
    if (take) begin
      msgBuf[idx] <= iLast ? lastWord : iDat;
    end else if (state == PAD) begin
      msgBuf[idx] <= padWord;
    end
  end

  always_ff @(posedge iClk) begin
    coreRst <= !reset_n;
  end

  assign oCoreRst     = coreRst;
  assign oDigest      = digest;
  assign oDigestValid = digestValid;

endmodule

// File: tb/tb_sha1_msg_ctrl.sv
// Bench for sha1_msg_ctrl: behavioural SHA-1 core plus a byte-level padding
// and digest reference model.
module tb_sha1_msg_ctrl;

  localparam logic [159:0] HINIT = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
  localparam int LIMIT = 4000;

  logic         iClk = 1'b0;
  logic         reset_n;
  logic [31:0]  iDat;
  logic         iValid;
  logic         iLast;
  logic [1:0]   iBytes;
  logic         oAccept;
  logic [31:0]  oCoreDat;
  logic         oCoreValid;
  logic         oCoreInitial;
  logic         oCoreRst;
  logic         iCoreReady;
  logic [159:0] iCoreDat;
  logic [159:0] oDigest;
  logic         oDigestValid;

  always #5 iClk = ~iClk;

  sha1_msg_ctrl dut (
    .iClk         (iClk),
    .reset_n      (reset_n),
    .iDat         (iDat),
    .iValid       (iValid),
    .iLast        (iLast),
    .iBytes       (iBytes),
    .oAccept      (oAccept),
    .oCoreDat     (oCoreDat),
    .oCoreValid   (oCoreValid),
    .oCoreInitial (oCoreInitial),
    .oCoreRst     (oCoreRst),
    .iCoreReady   (iCoreReady),
    .iCoreDat     (iCoreDat),
    .oDigest      (oDigest),
    .oDigestValid (oDigestValid)
  );

  int passCnt = 0;
  int chkCnt  = 0;
  int failCnt = 0;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    chkCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] sha1Compress(input logic [159:0] h, input logic [31:0] blk [16]);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = blk[i];
    for (int i = 16; i < 80; i++) begin
      t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {t[30:0], t[31]};
    end
    {a, b, c, d, e} = h;
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction

  // Behavioural core: takes 16 words, ready returns ~81 cycles after the first.
  logic         busy = 1'b0;
  logic [159:0] coreH = '0;
  logic [31:0]  wbuf [16];
  logic         useInit = 1'b0;
  int           cyc = 0;
  int           wcnt = 0;
  int           gapCnt = 0;
  logic [31:0]  burstQ [$];
  logic         initQ [$];

  assign iCoreReady = !busy;
  assign iCoreDat   = coreH;

  always @(posedge iClk) begin
    if (oCoreRst) begin
      busy <= 1'b0;
      cyc  <= 0;
      wcnt <= 0;
    end else begin
      if (oCoreValid) burstQ.push_back(oCoreDat);
      if (!busy) begin
        if (oCoreValid) begin
          busy    <= 1'b1;
          cyc     <= 1;
          wcnt    <= 1;
          wbuf[0] <= oCoreDat;
          useInit <= oCoreInitial;
          initQ.push_back(oCoreInitial);
        end
      end else begin
        cyc <= cyc + 1;
        if (wcnt < 16) begin
          if (oCoreValid) begin
            wbuf[wcnt] <= oCoreDat;
            wcnt <= wcnt + 1;
          end else begin
            gapCnt <= gapCnt + 1;
          end
        end
        if (cyc == 80) begin
          busy  <= 1'b0;
          coreH <= sha1Compress(useInit ? HINIT : coreH, wbuf);
        end
      end
    end
  end

  logic [159:0] digQ [$];
  int           accVio = 0;

  always @(negedge iClk) begin
    if (oDigestValid) digQ.push_back(oDigest);
    if (oAccept && (oCoreValid || !iCoreReady)) accVio <= accVio + 1;
  end

  logic [7:0]   msg [$];
  logic [31:0]  expW [$];
  logic [159:0] expDig;
  int           stall16;

  task automatic buildExp();
    logic [7:0]  p [$];
    logic [63:0] len;
    logic [31:0] blk [16];
    logic [159:0] h;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    len = 64'(msg.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(len[k*8 +: 8]);
    expW.delete();
    for (int i = 0; i < p.size(); i += 4) expW.push_back({p[i], p[i+1], p[i+2], p[i+3]});
    h = HINIT;
    for (int b = 0; b < expW.size() / 16; b++) begin
      for (int j = 0; j < 16; j++) blk[j] = expW[b*16 + j];
      h = sha1Compress(h, blk);
    end
    expDig = h;
  endtask

  task automatic sendWord(input logic [31:0] w, input logic last, input logic [1:0] nb, output int waited);
    iValid = 1'b1; iDat = w; iLast = last; iBytes = nb;
    waited = 0;
    while (!oAccept && waited < LIMIT) begin
      @(negedge iClk);
      waited++;
    end
    if (waited >= LIMIT) begin
      $display("FAIL accept_timeout waited=%0d limit=%0d", waited, LIMIT);
      $fatal(1);
    end
    @(negedge iClk);
  endtask

  task automatic sendMsg(input bit hold);
    int n, nw, waited;
    logic [31:0] w;
    n  = msg.size();
    nw = (n + 3) / 4;
    for (int i = 0; i < nw; i++) begin
      if (!hold) begin
        repeat ($urandom_range(0, 2)) begin
          iValid = 1'b0; iLast = 1'b0; iDat = $urandom;
          @(negedge iClk);
        end
      end
      w = $urandom;
      for (int j = 0; j < 4; j++) if (4*i + j < n) w[31-8*j -: 8] = msg[4*i + j];
      sendWord(w, i == nw - 1, (i == nw - 1) ? 2'(n % 4) : 2'd0, waited);
      if (i == 16) stall16 = waited;
    end
    iValid = 1'b0; iLast = 1'b0; iBytes = 2'd0;
  endtask

  task automatic runMsg(input string tag, input bit hold, output int bBase, output int dBase);
    int iBase, gBase, waited, nblk;
    bBase = burstQ.size(); iBase = initQ.size(); dBase = digQ.size(); gBase = gapCnt;
    buildExp();
    sendMsg(hold);
    waited = 0;
    while (digQ.size() == dBase && waited < LIMIT) begin
      @(negedge iClk);
      waited++;
    end
    repeat (3) @(negedge iClk);
    chk({tag, "_pulses"}, 160'(digQ.size() - dBase), 160'd1);
    chk({tag, "_nwords"}, 160'(burstQ.size() - bBase), 160'(expW.size()));
    for (int i = 0; i < expW.size() && bBase + i < burstQ.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), 160'(burstQ[bBase + i]), 160'(expW[i]));
    nblk = expW.size() / 16;
    chk({tag, "_nblocks"}, 160'(initQ.size() - iBase), 160'(nblk));
    for (int b = 0; b < nblk && iBase + b < initQ.size(); b++)
      chk($sformatf("%s_init%0d", tag, b), 160'(initQ[iBase + b]), 160'(b == 0));
    chk({tag, "_gaps"}, 160'(gapCnt - gBase), 160'd0);
    if (digQ.size() > dBase) chk({tag, "_digest"}, digQ[dBase], expDig);
  endtask

  task automatic setA(input int n);
    msg.delete();
    repeat (n) msg.push_back(8'h61);
  endtask

  task automatic setRand(input int n);
    msg.delete();
    repeat (n) msg.push_back(8'($urandom));
  endtask

  initial begin
    int bB, dB, cnt, r, n;
    int lens [4] = '{1, 52, 60, 63};
    reset_n = 1'b0; iValid = 1'b0; iDat = '0; iLast = 1'b0; iBytes = 2'd0; stall16 = 0;
    repeat (3) @(negedge iClk);
    chk("rst_accept", 160'(oAccept), 160'd0);
    chk("rst_coreValid", 160'(oCoreValid), 160'd0);
    chk("rst_coreInitial", 160'(oCoreInitial), 160'd0);
    chk("rst_digestValid", 160'(oDigestValid), 160'd0);
    chk("rst_digest", oDigest, 160'd0);
    chk("rst_coreRst", 160'(oCoreRst), 160'd1);
    reset_n = 1'b1;
    chk("release_accept_low", 160'(oAccept), 160'd0);
    @(negedge iClk);
    chk("release_accept_high", 160'(oAccept), 160'd1);
    chk("release_coreRst", 160'(oCoreRst), 160'd0);

    msg = '{8'h61, 8'h62, 8'h63};
    runMsg("abc", 1'b0, bB, dB);
    chk("abc_w0_const", 160'(burstQ[bB]), 160'h61626380);
    chk("abc_w15_const", 160'(burstQ[bB + 15]), 160'h18);
    chk("abc_digest_const", digQ[dB], 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);

    setA(55);
    runMsg("a55", 1'b0, bB, dB);
    chk("a55_w13_const", 160'(burstQ[bB + 13]), 160'h61616180);
    chk("a55_w15_const", 160'(burstQ[bB + 15]), 160'h1B8);

    setA(56);
    runMsg("a56", 1'b0, bB, dB);
    chk("a56_b1w0_const", 160'(burstQ[bB + 16]), 160'h0);
    chk("a56_b1w15_const", 160'(burstQ[bB + 31]), 160'h1C0);

    setRand(64);
    runMsg("al64", 1'b0, bB, dB);
    chk("al64_b1w0_const", 160'(burstQ[bB + 16]), 160'h80000000);
    chk("al64_b1w15_const", 160'(burstQ[bB + 31]), 160'h200);

    foreach (lens[i]) begin
      setRand(lens[i]);
      runMsg($sformatf("len%0d", lens[i]), 1'($urandom_range(0, 1)), bB, dB);
    end
    for (int t = 0; t < 4; t++) begin
      n = $urandom_range(1, 140);
      setRand(n);
      runMsg($sformatf("rnd%0d_len%0d", t, n), 1'($urandom_range(0, 1)), bB, dB);
    end

    setRand(80);
    runMsg("bp80", 1'b1, bB, dB);
    chk("bp80_stall", 160'(stall16 >= 81), 160'd1);

    msg = '{8'h61, 8'h62, 8'h63};
    dB = digQ.size();
    sendMsg(1'b0);
    cnt = 0; r = 0;
    while (cnt < 8 && r < LIMIT) begin
      @(negedge iClk);
      r++;
      if (oCoreValid) cnt++;
    end
    chk("rstmid_reached_w7", 160'(cnt), 160'd8);
    reset_n = 1'b0;
    @(negedge iClk);
    reset_n = 1'b1;
    r = 0;
    for (int k = 0; k < 4; k++) begin
      if (oCoreRst) r++;
      @(negedge iClk);
    end
    chk("rstmid_coreRst_cycles", 160'(r), 160'd1);
    chk("rstmid_coreValid", 160'(oCoreValid), 160'd0);
    repeat (200) @(negedge iClk);
    chk("rstmid_no_pulse", 160'(digQ.size() - dB), 160'd0);
    chk("rstmid_accept", 160'(oAccept), 160'd1);
    runMsg("abc_after_rst", 1'b0, bB, dB);
    chk("abc_after_rst_const", digQ[dB], 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);

    chk("accept_rules", 160'(accVio), 160'd0);

    $display("%0d/%0d checks passed", passCnt, chkCnt);
    $finish;
  end

endmodule
